// File: rtl/cr_sa_snapshot_reader_pkg.sv
// Shared types for the stats-aggregator snapshot reader: FSM states, word widths
// and the streamed word record carried through the output slice.
package cr_sa_snapshot_reader_pkg;

  localparam int RD_WORD_W = 32;
  localparam int RD_IDX_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    WAIT,
    LO,
    HI,
    DONE
  } rd_state_e;

  typedef struct packed {
    logic [RD_WORD_W-1:0] data;
    logic [RD_IDX_W-1:0]  idx;
    logic                 hi;
    logic                 last;
  } rd_word_t;

  // Upper half of a counter that has already been zero-extended to 64 bits.
  function automatic logic [RD_WORD_W-1:0] hi_half(input logic [63:0] v);
    return v[63:32];
  endfunction

endpackage

// File: rtl/cr_sa_snapshot_reader_if.sv
// Valid/ready word stream from the snapshot reader toward the CSR/telemetry sink.
interface cr_sa_snapshot_reader_if;
  import cr_sa_snapshot_reader_pkg::*;

  logic                 rd_valid;
  logic                 rd_ready;
  logic [RD_WORD_W-1:0] rd_data;
  logic [RD_IDX_W-1:0]  rd_idx;
  logic                 rd_hi;
  logic                 rd_last;

  modport master (
    output rd_valid, rd_data, rd_idx, rd_hi, rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_data, rd_idx, rd_hi, rd_last,
    output rd_ready
  );

endinterface

// File: rtl/cr_sa_rd_skid.sv
// One-entry registered output slice: payload holds while valid and not accepted,
// and a new word can be loaded in the same cycle the current one is taken.
module cr_sa_rd_skid
  import cr_sa_snapshot_reader_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  output logic     in_ready,
  input  rd_word_t in_word,
  output logic     out_valid,
  output rd_word_t out_word,
  input  logic     out_ready
);

  logic     valid_q, valid_d;
  rd_word_t word_q, word_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      word_d  = in_word;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end

  assign out_valid = valid_q;
  assign out_word  = word_q;

endmodule

// File: rtl/cr_sa_snapshot_reader.sv
// Snapshot readout engine: pulses snap (optionally clear), waits SNAP_LAT, then streams
// every counter as lo/hi words. CR_SA_RD_SKIP_ZERO_EN suppresses zero counters except the last.
module cr_sa_snapshot_reader
  import cr_sa_snapshot_reader_pkg::*;
#(
  parameter int NUM_CTRS = 64,
  parameter int SNAP_LAT = 4,
  parameter int CNT_W    = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_start,
  input  logic             rd_clear,
  input  logic [CNT_W-1:0] sa_snapshot [0:NUM_CTRS-1],
  output logic             sa_snap_req,
  output logic             sa_clear_req,
  output logic             rd_busy,
  output logic             rd_done,
  cr_sa_snapshot_reader_if.master rd_if
);

  localparam int WAIT_W = (SNAP_LAT > 1) ? $clog2(SNAP_LAT) : 1;
  localparam logic [RD_IDX_W-1:0] LAST_IDX = RD_IDX_W'(NUM_CTRS - 1);

  rd_state_e             state_q, state_d;
  logic [RD_IDX_W-1:0]   idx_q, idx_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  clr_q, clr_d;
  logic                  snap_req_q, clear_req_q, busy_q, done_q;

  logic                  accept;
  logic                  want_lo, want_hi, lo_ok;
  logic [63:0]           sel;
  logic                  push_valid;
  logic                  skid_in_ready;
  rd_word_t              push_word;
  rd_word_t              out_word;
  logic                  out_valid;

  assign accept = out_valid && rd_if.rd_ready;

  // The state names the word currently held in the slice, so the word for the
  // destination state is selected from idx_d and loaded on the same edge.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    clr_d   = clr_q;
    want_lo = 1'b0;
    want_hi = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          state_d = SNAP;
          clr_d   = rd_clear;
        end
      end
      SNAP: begin
        state_d = WAIT;
        wait_d  = WAIT_W'(SNAP_LAT - 1);
      end
      WAIT: begin
        if (wait_q == '0) begin
          state_d = LO;
          idx_d   = '0;
          want_lo = 1'b1;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      LO: begin
        if (!out_valid) begin
          // Only reachable while skipping zero counters: step to the next one.
          idx_d   = idx_q + 1'b1;
          want_lo = 1'b1;
        end else if (accept) begin
          state_d = HI;
          want_hi = 1'b1;
        end
      end
      HI: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = LO;
            idx_d   = idx_q + 1'b1;
            want_lo = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        clr_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    sel = 64'(sa_snapshot[idx_d]);
`ifdef CR_SA_RD_SKIP_ZERO_EN
    lo_ok = (sel != 64'd0) || (idx_d == LAST_IDX);
`else
    lo_ok = 1'b1;
`endif
    push_valid     = ((want_lo && lo_ok) || want_hi) && skid_in_ready;
    push_word.data = want_hi ? hi_half(sel) : sel[31:0];
    push_word.idx  = idx_d;
    push_word.hi   = want_hi;
    push_word.last = want_hi && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      clr_q       <= 1'b0;
      snap_req_q  <= 1'b0;
      clear_req_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      clr_q       <= clr_d;
      snap_req_q  <= (state_d == SNAP);
      clear_req_q <= (state_d == SNAP) && clr_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  cr_sa_rd_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push_valid),
    .in_ready  (skid_in_ready),
    .in_word   (push_word),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_ready (rd_if.rd_ready)
  );

  assign rd_if.rd_valid = out_valid;
  assign rd_if.rd_data  = out_word.data;
  assign rd_if.rd_idx   = out_word.idx;
  assign rd_if.rd_hi    = out_word.hi;
  assign rd_if.rd_last  = out_word.last;

  assign sa_snap_req  = snap_req_q;
  assign sa_clear_req = clear_req_q;
  assign rd_busy      = busy_q;
  assign rd_done      = done_q;

endmodule

// File: tb/tb_cr_sa_snapshot_reader.sv
// Scoreboard bench for cr_sa_snapshot_reader: expected words are queued at stimulus
// time and a negedge monitor pops and compares each accepted word.
module tb_cr_sa_snapshot_reader;
  import cr_sa_snapshot_reader_pkg::*;

`ifdef CR_SA_RD_SKIP_ZERO_EN
  localparam bit SKIPZ = 1'b1;
`else
  localparam bit SKIPZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_start;
  logic        rd_clear;
  logic [49:0] snap [0:63];
  logic        sa_snap_req, sa_clear_req, rd_busy, rd_done;

  cr_sa_snapshot_reader_if rd_if ();

  cr_sa_snapshot_reader #(.NUM_CTRS(64), .SNAP_LAT(4), .CNT_W(50)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_start     (rd_start),
    .rd_clear     (rd_clear),
    .sa_snapshot  (snap),
    .sa_snap_req  (sa_snap_req),
    .sa_clear_req (sa_clear_req),
    .rd_busy      (rd_busy),
    .rd_done      (rd_done),
    .rd_if        (rd_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int c0 = 0;
  int ready_mode = 0;
  int snap_cnt, clr_cnt, done_cnt, acc_cnt;
  int snap_cyc, clr_cyc, done_cyc, last_cyc, first_valid_cyc;
  rd_word_t exp_q [$];
  bit       prev_stall = 1'b0;
  rd_word_t held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) rd_if.rd_ready = 1'b1;
    else                 rd_if.rd_ready = ((cyc - c0) % 2) == 1;
  end

  always @(negedge clk) begin
    rd_word_t cur;
    rd_word_t e;
    cur = '{rd_if.rd_data, rd_if.rd_idx, rd_if.rd_hi, rd_if.rd_last};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (sa_snap_req)  begin snap_cnt++; snap_cyc = cyc; end
      if (sa_clear_req) begin clr_cnt++;  clr_cyc  = cyc; end
      if (rd_done)      begin done_cnt++; done_cyc = cyc; end
      if (prev_stall)
        check("stall_hold", {23'd0, rd_if.rd_valid, cur}, {23'd0, 1'b1, held});
      if (rd_if.rd_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (rd_if.rd_valid && rd_if.rd_ready) begin
        acc_cnt++;
        if (rd_if.rd_last) last_cyc = cyc;
        $display("[TB] word idx=%0d hi=%0d last=%0d data=%h", cur.idx, cur.hi, cur.last, cur.data);
        if (exp_q.size() == 0) begin
          check("extra_word", {24'd0, cur}, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("word", {24'd0, cur}, {24'd0, e});
        end
      end
      prev_stall = rd_if.rd_valid && !rd_if.rd_ready;
      held = cur;
    end
  end

  task automatic push_pair(input int i, input logic [31:0] lo, input logic [31:0] hi);
    exp_q.push_back('{lo, 6'(i), 1'b0, 1'b0});
    exp_q.push_back('{hi, 6'(i), 1'b1, i == 63});
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 64; i++) begin
      snap[i] = 50'(i) | (50'(i) << 40);
      if (!(SKIPZ && i == 0)) push_pair(i, 32'(i), 32'(i) << 8);
    end
  endtask

  task automatic start_pass(input bit clr);
    snap_cnt = 0; clr_cnt = 0; done_cnt = 0; acc_cnt = 0;
    first_valid_cyc = -1; last_cyc = -1; done_cyc = -1;
    @(posedge clk); #1;
    c0 = cyc;
    rd_start = 1'b1; rd_clear = clr;
    @(posedge clk); #1;
    rd_start = 1'b0; rd_clear = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_cnt == 0 && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_done_seen"}, 64'(done_cnt), 64'd1);
    @(posedge clk); #1;
    check({name, "_idle_busy"}, 64'(rd_busy), 64'd0);
    check({name, "_done_once"}, 64'(done_cnt), 64'd1);
    check({name, "_snap_once"}, 64'(snap_cnt), 64'd1);
    check({name, "_snap_cyc"}, 64'(snap_cyc), 64'(c0 + 1));
    check({name, "_done_after_last"}, 64'(done_cyc), 64'(last_cyc + 1));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (acc_cnt < n && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    check("reach_word", 64'(acc_cnt >= n), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; rd_start = 1'b0; rd_clear = 1'b0;
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 64; i++) snap[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {25'd0, sa_snap_req, sa_clear_req, rd_busy, rd_done, rd_if.rd_valid,
           rd_if.rd_data, rd_if.rd_idx, rd_if.rd_hi, rd_if.rd_last}, 64'd0);
    rst_n = 1'b1;

    // Continuous ready
    load_pattern();
    start_pass(1'b0);
    wait_done("p1");
    check("p1_no_clear", 64'(clr_cnt), 64'd0);
    if (!SKIPZ) begin
      check("p1_first_valid", 64'(first_valid_cyc), 64'(c0 + 6));
      check("p1_done_cyc", 64'(done_cyc), 64'(c0 + 134));
      check("p1_words", 64'(acc_cnt), 64'd128);
    end

    // Ready toggling every cycle
    ready_mode = 1;
    load_pattern();
    start_pass(1'b0);
    wait_done("p2");
    ready_mode = 0;
    if (!SKIPZ) begin
      check("p2_done_cyc", 64'(done_cyc), 64'(c0 + 262));
      check("p2_words", 64'(acc_cnt), 64'd128);
    end

    // rd_clear alone has no effect
    clr_cnt = 0; snap_cnt = 0;
    rd_clear = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rd_clear = 1'b0;
    check("clear_alone_clr", 64'(clr_cnt), 64'd0);
    check("clear_alone_busy", 64'(rd_busy), 64'd0);

    // Clear coincides with snap
    load_pattern();
    start_pass(1'b1);
    wait_done("p3");
    check("p3_clear_once", 64'(clr_cnt), 64'd1);
    check("p3_clear_with_snap", 64'(clr_cyc), 64'(snap_cyc));

    // rd_start mid-pass is ignored
    load_pattern();
    start_pass(1'b0);
    wait_acc(40);
    rd_start = 1'b1; rd_clear = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0; rd_clear = 1'b0;
    wait_done("p4");
    check("p4_no_clear", 64'(clr_cnt), 64'd0);
    if (!SKIPZ) check("p4_words", 64'(acc_cnt), 64'd128);

    // Async reset mid-pass, then restart
    load_pattern();
    start_pass(1'b0);
    wait_acc(70);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs",
          {25'd0, sa_snap_req, sa_clear_req, rd_busy, rd_done, rd_if.rd_valid,
           rd_if.rd_data, rd_if.rd_idx, rd_if.rd_hi, rd_if.rd_last}, 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midreset_no_done", 64'(done_cnt), 64'd0);
    load_pattern();
    start_pass(1'b0);
    wait_done("p5");

    // Sparse counters: only 3, 17, 63 nonzero
    for (int i = 0; i < 64; i++) snap[i] = '0;
    snap[3]  = 50'h0_0003_0000_0005;
    snap[17] = 50'h1_2345_6789_ABCD;
    snap[63] = 50'h3_FFFF_FFFF_FFFF;
    for (int i = 0; i < 64; i++) begin
      case (i)
        3:       push_pair(i, 32'h0000_0005, 32'h0000_0003);
        17:      push_pair(i, 32'h6789_ABCD, 32'h0001_2345);
        63:      push_pair(i, 32'hFFFF_FFFF, 32'h0003_FFFF);
        default: if (!SKIPZ) push_pair(i, 32'd0, 32'd0);
      endcase
    end
    start_pass(1'b0);
    wait_done("p6");
    check("p6_words", 64'(acc_cnt), SKIPZ ? 64'd6 : 64'd128);

    // All counters zero
    for (int i = 0; i < 64; i++) begin
      snap[i] = '0;
      if (!SKIPZ || i == 63) push_pair(i, 32'd0, 32'd0);
    end
    start_pass(1'b0);
    wait_done("p7");
    check("p7_words", 64'(acc_cnt), SKIPZ ? 64'd2 : 64'd128);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
